// File: rtl/approx_mult_pipe.sv
// Three-stage unsigned multiplier with a per-transaction exact/approximate mode.
// Approximate mode ORs each of the low APPROX_COLS product columns instead of summing them.
module approx_mult_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   num1,
    input  logic [WIDTH-1:0]   num2,
    input  logic               approx_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] w,
    output logic               out_approx
);

    localparam int PW   = 2 * WIDTH;
    localparam int HALF = WIDTH / 2;

    logic          advance_s;
    logic [PW-1:0] approx_mask_s;
    logic [PW-1:0] row_s;

    logic [PW-1:0] s1_lo_d, s1_hi_d, s1_l_d;
    logic [PW-1:0] s1_lo_q, s1_hi_q, s1_l_q;
    logic          s1_valid_q, s1_approx_q;

    logic [PW-1:0] s2_sum_d, s2_carry_d, s2_maj_s;
    logic [PW-1:0] s2_sum_q, s2_carry_q;
    logic          s2_valid_q, s2_approx_q;

    logic [PW-1:0] w_d;

    // The whole pipe moves together; only the output stage can stall it.
    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s || rst;

    // S1: partial-product rows, low columns diverted to the OR row in approximate mode.
    always_comb begin
        approx_mask_s = '0;
        row_s         = '0;
        s1_lo_d       = '0;
        s1_hi_d       = '0;
        s1_l_d        = '0;
        for (int c = 0; c < PW; c++) begin
            approx_mask_s[c] = approx_en && (c < APPROX_COLS);
        end
        for (int j = 0; j < WIDTH; j++) begin
            row_s  = {{WIDTH{1'b0}}, num1 & {WIDTH{num2[j]}}} << j;
            s1_l_d = s1_l_d | (row_s & approx_mask_s);
            row_s  = row_s & ~approx_mask_s;
            if (j < HALF) begin
                s1_lo_d = s1_lo_d + row_s;
            end else begin
                s1_hi_d = s1_hi_d + row_s;
            end
        end
    end

    // S2: 3:2 carry-save compression of the two half sums and the OR row.
    always_comb begin
        s2_maj_s   = (s1_lo_q & s1_hi_q) | (s1_lo_q & s1_l_q) | (s1_hi_q & s1_l_q);
        s2_sum_d   = s1_lo_q ^ s1_hi_q ^ s1_l_q;
        s2_carry_d = {s2_maj_s[PW-2:0], 1'b0};
    end

    // S3: final carry-propagate add.
    always_comb begin
        w_d = s2_sum_q + s2_carry_q;
    end

    // Valid bits and output registers, cleared by reset, frozen while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            out_valid  <= 1'b0;
            w          <= '0;
            out_approx <= 1'b0;
        end else if (advance_s) begin
            s1_valid_q <= in_valid;
            s2_valid_q <= s1_valid_q;
            out_valid  <= s2_valid_q;
            w          <= w_d;
            out_approx <= s2_approx_q;
        end else begin
            s1_valid_q <= s1_valid_q;
            s2_valid_q <= s2_valid_q;
            out_valid  <= out_valid;
            w          <= w;
            out_approx <= out_approx;
        end
    end

    // Intermediate datapath registers; their contents only matter behind a valid bit.
    always_ff @(posedge clk) begin
        if (advance_s) begin
            s1_lo_q     <= s1_lo_d;
            s1_hi_q     <= s1_hi_d;
            s1_l_q      <= s1_l_d;
            s1_approx_q <= approx_en;
            s2_sum_q    <= s2_sum_d;
            s2_carry_q  <= s2_carry_d;
            s2_approx_q <= s1_approx_q;
        end else begin
            s1_lo_q     <= s1_lo_q;
            s1_hi_q     <= s1_hi_q;
            s1_l_q      <= s1_l_q;
            s1_approx_q <= s1_approx_q;
            s2_sum_q    <= s2_sum_q;
            s2_carry_q  <= s2_carry_q;
            s2_approx_q <= s2_approx_q;
        end
    end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Scoreboard bench for approx_mult_pipe (WIDTH=8, APPROX_COLS=4): the driver queues
// expected products on acceptance, an independent monitor checks every delivery.
module tb_approx_mult_pipe;

    localparam int W  = 8;
    localparam int AC = 4;

    logic           clk, rst, in_valid, in_ready, approx_en, out_valid, out_ready, out_approx;
    logic [W-1:0]   num1, num2;
    logic [2*W-1:0] w;

    typedef struct {
        logic [2*W-1:0] w;
        logic           ap;
        int             prod;
        int             cyc;
        bit             chk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    approx_mult_pipe #(.WIDTH(W), .APPROX_COLS(AC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .num1(num1), .num2(num2), .approx_en(approx_en),
        .out_valid(out_valid), .out_ready(out_ready), .w(w), .out_approx(out_approx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Bit-level reference: exact sum above AC, per-column OR below it.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic ap);
        int             hs;
        logic [2*W-1:0] lbits;
        hs    = 0;
        lbits = '0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                if (a[i] && b[j]) begin
                    if (!ap || (i + j >= AC)) hs = hs + (1 << (i + j));
                    else lbits[i+j] = 1'b1;
                end
            end
        end
        return 16'(hs) + lbits;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ap,
                        input logic [2*W-1:0] e, input bit chk);
        exp_t item;
        bit   acc;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        num1      = a;
        num2      = b;
        approx_en = ap;
        acc       = 1'b0;
        for (int t = 0; t < 500 && !acc; t++) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                item.w    = e;
                item.ap   = ap;
                item.prod = int'(a) * int'(b);
                item.cyc  = cyc;
                item.chk  = chk;
                sb.push_back(item);
                acc = 1'b1;
            end
        end
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    // Monitor: pops on each delivery, checks stall stability and reset behaviour.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("in_ready_in_reset", int'(in_ready), 1);
            sb.delete();
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_output", int'(w), -1);
            end else if (out_ready) begin
                e = sb.pop_front();
                check("w", int'(w), int'(e.w));
                check("out_approx", int'(out_approx), int'(e.ap));
                if (e.chk) check("latency", cyc - e.cyc, 3);
                if (e.ap) begin
                    checks++;
                    if (int'(w) > e.prod) begin
                        errors++;
                        $display("FAIL approx_bound: got %0d exceeds exact %0d", w, e.prod);
                    end
                end
            end else begin
                check("w_frozen", int'(w), int'(sb[0].w));
                check("in_ready_stall", int'(in_ready), 0);
            end
        end
    end

    bit rnd_done;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        num1      = '0;
        num2      = '0;
        approx_en = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_w", int'(w), 0);
        check("reset_out_approx", int'(out_approx), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Corner operands, back-to-back mode switch, latency checked.
        send(8'd255, 8'd255, 1'b0, 16'd65025, 1'b1);
        send(8'd255, 8'd255, 1'b1, 16'd64991, 1'b1);
        send(8'd3,   8'd3,   1'b1, 16'd7,     1'b1);
        send(8'd3,   8'd5,   1'b1, 16'd15,    1'b1);
        send(8'd3,   8'd3,   1'b0, 16'd9,     1'b1);
        send(8'd0,   8'd200, 1'b1, 16'd0,     1'b1);
        send(8'd16,  8'd16,  1'b1, 16'd256,   1'b1);
        send(8'd7,   8'd1,   1'b1, 16'd7,     1'b1);
        idle(6);

        // Six back-to-back inputs with the consumer stalled for four cycles.
        fork
            begin
                send(8'd10,  8'd20,  1'b0, 16'd200,   1'b0);
                send(8'd15,  8'd15,  1'b1, model(8'd15, 8'd15, 1'b1), 1'b0);
                send(8'd100, 8'd3,   1'b0, 16'd300,   1'b0);
                send(8'd255, 8'd1,   1'b1, 16'd255,   1'b0);
                send(8'd128, 8'd128, 1'b0, 16'd16384, 1'b0);
                send(8'd11,  8'd13,  1'b1, model(8'd11, 8'd13, 1'b1), 1'b0);
                idle(1);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(8);
        check("stall_drained", sb.size(), 0);

        // Reset with three transactions in flight.
        send(8'd9,  8'd9,  1'b0, 16'd81,  1'b0);
        send(8'd12, 8'd12, 1'b1, model(8'd12, 8'd12, 1'b1), 1'b0);
        send(8'd50, 8'd2,  1'b0, 16'd100, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_w", int'(w), 0);
        idle(8);

        // Random operands, modes, input gaps and consumer back-pressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 10000; n++) begin
                    logic [W-1:0] a, b;
                    logic         ap;
                    a  = W'($urandom_range(0, 255));
                    b  = W'($urandom_range(0, 255));
                    ap = 1'($urandom_range(0, 1));
                    send(a, b, ap, model(a, b, ap), 1'b0);
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                idle(1);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        for (int t = 0; t < 200 && sb.size() != 0; t++) @(posedge clk);
        repeat (4) @(posedge clk);
        check("final_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
